// File: rtl/param_code_lock_fsm_pkg.sv
// Shared definitions for the parametrised keypad code lock: state encoding
// (kept as plain constants so the single-bit lock and its benches can reuse it).
package param_code_lock_fsm_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_ENTRY   = 2'd0;
    localparam logic [STATE_W-1:0] ST_OPEN    = 2'd1;
    localparam logic [STATE_W-1:0] ST_LOCKOUT = 2'd2;

    // Largest of three cycle counts; sizes the single shared timer.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/param_code_lock_fsm_lock_timer.sv
// Loadable down-counter with a registered done flag. One instance serves the
// open hold, the lockout and the entry timeout, which never overlap.
module lock_timer #(
    parameter int WIDTH = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;
    logic             r_done;

    // Count register: load wins over decrement, saturates at zero.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= {WIDTH{1'b0}};
            r_done  <= 1'b1;
        end else if (i_load) begin
            r_count <= i_load_val;
            r_done  <= (i_load_val == {WIDTH{1'b0}});
        end else if (r_count != {WIDTH{1'b0}}) begin
            r_count <= r_count - WIDTH'(1);
            r_done  <= (r_count == WIDTH'(1));
        end else begin
            r_done  <= 1'b1;
        end
    end

    assign o_done = r_done;

endmodule

// File: rtl/param_code_lock_fsm.sv
// Keypad code lock: checks a CODE_LEN-digit entry, holds the door open on a match,
// pulses Err on a mismatch and enforces a timed lockout after MAX_TRIES failures.
module param_code_lock_fsm
    import param_code_lock_fsm_pkg::*;
#(
    parameter int DIGIT_W       = 4,
    parameter int CODE_LEN      = 4,
    parameter int MAX_TRIES     = 3,
    parameter int OPEN_CYCLES   = 8,
    parameter int LOCK_CYCLES   = 16,
    parameter int ENTRY_TIMEOUT = 32
) (
    input  logic                                 Clk,
    input  logic                                 Rst,
    input  logic [DIGIT_W-1:0]                   Key,
    input  logic                                 Key_Valid,
    input  logic [CODE_LEN*DIGIT_W-1:0]          Code,
    output logic                                 Out,
    output logic                                 Err,
    output logic                                 Locked,
    output logic [$clog2(MAX_TRIES+1)-1:0]       Tries_Left
);

    localparam int CODE_W = CODE_LEN * DIGIT_W;
    localparam int CNT_W  = $clog2(CODE_LEN + 1);
    localparam int TL_W   = $clog2(MAX_TRIES + 1);
    localparam int TMR_W  = $clog2(max3(OPEN_CYCLES, LOCK_CYCLES, ENTRY_TIMEOUT) + 1);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(CODE_LEN - 1);
    localparam logic [TL_W-1:0]  TRIES_MAX  = TL_W'(MAX_TRIES);

    logic [STATE_W-1:0] r_state,      w_state_nxt;
    logic [CNT_W-1:0]   r_digit_cnt,  w_cnt_nxt;
    logic               r_mismatch,   w_mis_nxt;
    logic [TL_W-1:0]    r_fail_cnt,   w_fail_nxt;
    logic [TL_W-1:0]    r_tries_left, w_tries_nxt;
    logic [CODE_W-1:0]  r_code,       w_code_nxt;
    logic               r_out;
    logic               r_err,        w_err_nxt;
    logic               r_locked;

    logic [CODE_W-1:0]  w_code_sel;
    logic [DIGIT_W-1:0] w_ref_digit;
    logic               w_digit_bad;
    logic [TL_W-1:0]    w_fail_inc;
    logic               w_tmr_load;
    logic [TMR_W-1:0]   w_tmr_val;
    logic               w_tmr_done;

    // The first digit of an attempt compares against the live code, which is then latched.
    assign w_code_sel  = (r_digit_cnt == CNT_W'(0)) ? Code : r_code;
    assign w_ref_digit = DIGIT_W'(w_code_sel >> (32'(r_digit_cnt) * DIGIT_W));
    assign w_digit_bad = (Key != w_ref_digit);
    assign w_fail_inc  = r_fail_cnt + TL_W'(1);

    lock_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .i_clk      (Clk),
        .i_rst      (Rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    // Next-state and attempt bookkeeping.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_digit_cnt;
        w_mis_nxt   = r_mismatch;
        w_fail_nxt  = r_fail_cnt;
        w_tries_nxt = r_tries_left;
        w_code_nxt  = r_code;
        w_err_nxt   = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_val   = TMR_W'(0);
        case (r_state)
            ST_ENTRY: begin
                if (Key_Valid) begin
                    w_code_nxt = w_code_sel;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMR_W'(ENTRY_TIMEOUT - 1);
                    if (r_digit_cnt == LAST_DIGIT) begin
                        w_cnt_nxt = CNT_W'(0);
                        w_mis_nxt = 1'b0;
                        if (!(r_mismatch || w_digit_bad)) begin
                            w_state_nxt = ST_OPEN;
                            w_fail_nxt  = TL_W'(0);
                            w_tries_nxt = TRIES_MAX;
                            w_tmr_val   = TMR_W'(OPEN_CYCLES - 1);
                        end else if (w_fail_inc < TRIES_MAX) begin
                            w_err_nxt   = 1'b1;
                            w_fail_nxt  = w_fail_inc;
                            w_tries_nxt = TRIES_MAX - w_fail_inc;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_LOCKOUT;
                            w_fail_nxt  = w_fail_inc;
                            w_tries_nxt = TL_W'(0);
                            w_tmr_val   = TMR_W'(LOCK_CYCLES - 1);
                        end
                    end else begin
                        w_cnt_nxt = r_digit_cnt + CNT_W'(1);
                        w_mis_nxt = r_mismatch | w_digit_bad;
                    end
                end else if ((r_digit_cnt != CNT_W'(0)) && w_tmr_done) begin
                    // Idle too long: drop the partial entry silently.
                    w_cnt_nxt = CNT_W'(0);
                    w_mis_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_digit_cnt;
                end
            end
            ST_OPEN: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_ENTRY;
                end else begin
                    w_state_nxt = ST_OPEN;
                end
            end
            ST_LOCKOUT: begin
                if (w_tmr_done) begin
                    w_state_nxt = ST_ENTRY;
                    w_fail_nxt  = TL_W'(0);
                    w_tries_nxt = TRIES_MAX;
                end else begin
                    w_state_nxt = ST_LOCKOUT;
                end
            end
            default: begin
                w_state_nxt = ST_ENTRY;
                w_cnt_nxt   = CNT_W'(0);
                w_mis_nxt   = 1'b0;
                w_fail_nxt  = TL_W'(0);
                w_tries_nxt = TRIES_MAX;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= ST_ENTRY;
            r_digit_cnt  <= CNT_W'(0);
            r_mismatch   <= 1'b0;
            r_fail_cnt   <= TL_W'(0);
            r_tries_left <= TRIES_MAX;
            r_code       <= {CODE_W{1'b0}};
            r_out        <= 1'b0;
            r_err        <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_digit_cnt  <= w_cnt_nxt;
            r_mismatch   <= w_mis_nxt;
            r_fail_cnt   <= w_fail_nxt;
            r_tries_left <= w_tries_nxt;
            r_code       <= w_code_nxt;
            r_out        <= (w_state_nxt == ST_OPEN);
            r_err        <= w_err_nxt;
            r_locked     <= (w_state_nxt == ST_LOCKOUT);
        end
    end

    assign Out        = r_out;
    assign Err        = r_err;
    assign Locked     = r_locked;
    assign Tries_Left = r_tries_left;

endmodule
